de_stage_reg: RTL and testbench
===============================

// Module: de_stage_reg
// PURPOSE
//  Parametrised decode/execute pipeline stage register with valid/ready handshake,
//  flush-to-bubble and a saturating stall counter.
//  Sits between decode and execute. Carries the control word, destination and source
//  register numbers, and the 16-bit address/immediate.
//  Adds back-pressure and hazard flush, which the fixed D/E latch lacked.
// PARAMETERS
//  CTRL_W   14  control-signal bus width
//  DST_W    3   destination register number width
//  SRC_W    4   source register number width (each of src1, src2)
//  ADDR_W   16  address/immediate width
//  CNT_W    16  stall-counter width
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       reset, synchronous, active-low
//  flush      in   1       kill every held instruction (branch/hazard squash)
//  in_valid   in   1       decode offers an instruction
//  in_ready   out  1       stage can accept this cycle
//  in_ctrl    in   CTRL_W  control word
//  in_dst     in   DST_W   destination register number
//  in_src1    in   SRC_W   source 1 register number
//  in_src2    in   SRC_W   source 2 register number
//  in_addr    in   ADDR_W  address/immediate
//  out_valid  out  1       execute-side instruction valid
//  out_ready  in   1       execute consumes this cycle
//  out_ctrl/out_dst/out_src1/out_src2/out_addr  out  per-field width  registered payload
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - Priority at each posedge: reset==0 > flush==1 > normal handshake.
//  - Reset: out_valid=0; all out_* fields=0; skid empty; stall_cnt=0.
//  - Reset mid-transfer discards any held or offered instruction.
//  - Accept = in_valid & in_ready. Move out = out_valid & out_ready.
//  - Latency is 1 cycle from accept to out_valid=1 when the output slot is empty or draining.
//  - When the output slot empties with nothing to load, out_valid=0 and every out_* field
//    is forced to 0, so ctrl=0 acts as a NOP bubble.
//  - Flush: out_valid=0, out_* fields=0, skid cleared.
//    The instruction offered in the flush cycle is dropped, even if in_ready=1.
//  - stall_cnt: +1 on every cycle with out_valid & ~out_ready, including the flush cycle.
//    Holds at 2^CNT_W-1. Cleared only by reset.
//  - Output fields never change while out_valid & ~out_ready (hold rule).
//  - Handshake must not produce a combinational loop:
//    - in_valid must not depend on in_ready.
//    - out_ready may depend on out_valid.
// CONFIGURATION
//  DE_STAGE_SKID_EN defined:
//  - Adds a 1-entry skid slot.
//  - in_ready = ~skid_valid, taken directly from a flop.
//  - Accept while out_valid & ~out_ready: the instruction goes to the skid slot.
//  - On move-out with skid_valid: skid contents load the output, skid empties.
//  - Full throughput under back-pressure; order is always preserved.
//  DE_STAGE_SKID_EN undefined:
//  - No skid slot; in_ready = out_ready | ~out_valid, which is combinational.
// STRUCTURE
//  - Package de_pipe_pkg holds:
//    - the default width localparams (CTRL_W, DST_W, SRC_W, ADDR_W);
//    - a packed struct de_payload_t {ctrl, dst, src1, src2, addr};
//    - the constant DE_BUBBLE = '0.
//  - Sub-module de_skid_slot: payload register plus valid flop with load/clear.
//    It is instantiated only under DE_STAGE_SKID_EN.
//  - Top level holds the output register, handshake logic and stall counter.
// TESTING
//  1. Reset: hold reset=0 one edge with in_valid=1, in_ctrl=14'h3FFF
//     -> out_valid=0, out_ctrl=0, out_addr=0, stall_cnt=0, in_ready=1.
//  2. Stream: out_ready=1, in_valid=1, in_addr=16'h0010..16'h0014 on consecutive cycles
//     -> same addresses on out_addr one cycle later, back-to-back, out_valid=1 throughout.
//  3. Back-pressure: out_valid=1, out_ready=0 for 3 cycles
//     -> output fields held, stall_cnt=3.
//     - With SKID_EN: one more instruction is accepted, then in_ready=0.
//     - Then out_ready=1 -> both instructions emerge in order.
//  4. Flush while stalled with skid full
//     -> next cycle out_valid=0, out_ctrl=0, in_ready=1, skid empty.
//  5. Flush with in_valid=1, in_dst=3'd5 in the same cycle
//     -> instruction dropped; out_valid stays 0 the following cycle.
//  6. Saturation: CNT_W=2, stall 5 cycles -> stall_cnt=3 and stays at 3.
//     Reset -> stall_cnt=0.

Source files
------------

// File: rtl/de_pipe_pkg.sv
// Shared types and default widths for the decode/execute stage register.
// Payload struct is the default-width view of what travels from decode to execute.
// DE_BUBBLE is the all-zero payload; ctrl=0 acts as a NOP in execute.
package de_pipe_pkg;

  localparam int CTRL_W = 14;
  localparam int DST_W  = 3;
  localparam int SRC_W  = 4;
  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DST_W-1:0]  dst;
    logic [SRC_W-1:0]  src1;
    logic [SRC_W-1:0]  src2;
    logic [ADDR_W-1:0] addr;
  } de_payload_t;

  localparam de_payload_t DE_BUBBLE = '0;

endpackage

// File: rtl/de_skid_slot.sv
// One-entry holding slot: payload register plus valid flop.
// Latency: loaded payload visible the cycle after ld_i.
// Backpressure: none of its own; the parent decides when to load and clear.
module de_skid_slot
  import de_pipe_pkg::*;
#(
  parameter int W = $bits(de_payload_t)
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  // Clear wins over load; clearing also zeroes the payload so stale data never lingers.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (ld_i) begin
      vld_q <= 1'b1;
      dat_q <= dat_i;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/de_stage_reg.sv
// Decode/execute stage register with valid/ready handshake, flush-to-bubble, stall counter.
// Latency: 1 cycle from accept to out_valid when the output slot is empty or draining.
// Backpressure: without DE_STAGE_SKID_EN in_ready = out_ready | ~out_valid; with it, a
// one-entry skid slot gives full throughput and in_ready comes straight from a flop.
module de_stage_reg #(
  parameter int CTRL_W = de_pipe_pkg::CTRL_W,
  parameter int DST_W  = de_pipe_pkg::DST_W,
  parameter int SRC_W  = de_pipe_pkg::SRC_W,
  parameter int ADDR_W = de_pipe_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [SRC_W-1:0]  in_src1,
  input  logic [SRC_W-1:0]  in_src2,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DST_W-1:0]  out_dst,
  output logic [SRC_W-1:0]  out_src1,
  output logic [SRC_W-1:0]  out_src2,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  stall_cnt
);
  import de_pipe_pkg::*;

  localparam int PAY_W = CTRL_W + DST_W + 2*SRC_W + ADDR_W;
  localparam logic [PAY_W-1:0] BUBBLE = PAY_W'(DE_BUBBLE);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay_q, out_pay_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stalled;
  logic             accept;
  logic             skid_vld;
  logic [PAY_W-1:0] skid_pay;

  assign in_pay  = {in_ctrl, in_dst, in_src1, in_src2, in_addr};
  assign stalled = out_valid_q & ~out_ready;
  assign accept  = in_valid & in_ready;

`ifdef DE_STAGE_SKID_EN
  logic skid_ld;
  logic skid_clr;

  // Skid only catches an instruction accepted while the output is held.
  assign in_ready = ~skid_vld;
  assign skid_ld  = reset & ~flush & accept & stalled;
  assign skid_clr = ~reset | flush | (out_valid_q & out_ready & skid_vld);

  de_skid_slot #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .clr_i (skid_clr),
    .ld_i  (skid_ld),
    .dat_i (in_pay),
    .vld_o (skid_vld),
    .dat_o (skid_pay)
  );
`else
  assign skid_vld = 1'b0;
  assign skid_pay = '0;
  assign in_ready = out_ready | ~out_valid_q;
`endif

  // Output slot next state: reset/flush force a bubble, otherwise refill when not held.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pay_d   = out_pay_q;
    if (!reset || flush) begin
      out_valid_d = 1'b0;
      out_pay_d   = BUBBLE;
    end else if (!stalled) begin
      if (skid_vld) begin
        out_valid_d = 1'b1;
        out_pay_d   = skid_pay;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pay_d   = in_pay;
      end else begin
        out_valid_d = 1'b0;
        out_pay_d   = BUBBLE;
      end
    end
  end

  // Stall counter: counts held cycles (flush cycles included), saturates, reset-only clear.
  always_comb begin
    stall_d = stall_q;
    if (!reset) begin
      stall_d = '0;
    end else if (stalled && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers; synchronous reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    out_valid_q <= out_valid_d;
    out_pay_q   <= out_pay_d;
    stall_q     <= stall_d;
  end

  assign out_valid = out_valid_q;
  assign {out_ctrl, out_dst, out_src1, out_src2, out_addr} = out_pay_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_de_stage_reg.sv
module tb_de_stage_reg;
  import de_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DST_W-1:0]  in_dst, out_dst;
  logic [SRC_W-1:0]  in_src1, in_src2, out_src1, out_src2;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic [15:0]       stall_cnt;

  // Second instance with a 2-bit counter for saturation; shares all inputs.
  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DST_W-1:0]  s_out_dst;
  logic [SRC_W-1:0]  s_out_src1, s_out_src2;
  logic [ADDR_W-1:0] s_out_addr;
  logic [1:0]        s_stall_cnt;

  int checks = 0;
  int errors = 0;
  de_payload_t sb[$];

  de_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_dst(out_dst), .out_src1(out_src1), .out_src2(out_src2),
    .out_addr(out_addr), .stall_cnt(stall_cnt)
  );

  de_stage_reg #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2), .in_addr(in_addr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_dst(s_out_dst), .out_src1(s_out_src1), .out_src2(s_out_src2),
    .out_addr(s_out_addr), .stall_cnt(s_stall_cnt)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor/scoreboard: samples on the falling edge, i.e. the state the next posedge acts on.
  logic        prev_stall = 1'b0;
  de_payload_t prev_pay   = '0;
  always @(negedge clk) begin : monitor
    de_payload_t o;
    de_payload_t e;
    o = {out_ctrl, out_dst, out_src1, out_src2, out_addr};
    if (out_valid !== 1'b1) chk("bubble_fields", o, DE_BUBBLE);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_fields", o, prev_pay);
    end
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output %0h with no expected entry", o);
      end else begin
        e = sb.pop_front();
        chk("sb_payload", o, e);
      end
    end
    if (!reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back({in_ctrl, in_dst, in_src1, in_src2, in_addr});
    prev_stall = reset && !flush && out_valid && !out_ready;
    prev_pay   = o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DST_W-1:0] d,
                       input logic [ADDR_W-1:0] a);
    in_valid = v;
    in_ctrl  = c;
    in_dst   = d;
    in_src1  = SRC_W'(a[3:0]);
    in_src2  = ~SRC_W'(a[3:0]);
    in_addr  = a;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    // 1. Reset with an instruction on offer
    drive(1'b1, 14'h3FFF, 3'd7, 16'hFFFF);
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // 2. Back-to-back stream, one-cycle latency
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, CTRL_W'(14'h100 + i), DST_W'(i), ADDR_W'(16'h0010 + i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_addr", out_addr, 16'h0010 + i);
    end

    // 3. Back-pressure: hold 0x0014, offer 0x0020
    out_ready = 1'b0;
    drive(1'b1, 14'h0AA, 3'd2, 16'h0020);
    step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_addr_held", out_addr, 16'h0014);
`ifdef DE_STAGE_SKID_EN
    in_valid = 1'b0;
`endif
    step();
    step();
    chk("bp_stall_cnt3", stall_cnt, 3);
    chk("bp_addr_held3", out_addr, 16'h0014);
    chk("sat_cnt3", s_stall_cnt, 3);
    step();
    step();
    chk("bp_stall_cnt5", stall_cnt, 5);
    chk("sat_cnt_holds", s_stall_cnt, 3);
    out_ready = 1'b1;
    step();
    chk("rel_valid", out_valid, 1);
    chk("rel_addr", out_addr, 16'h0020);
    in_valid = 1'b0;
    step();
    chk("rel_drain_valid", out_valid, 0);
    chk("rel_drain_ctrl", out_ctrl, 0);

    // 4. Flush while stalled (skid full when present)
    out_ready = 1'b0;
    drive(1'b1, 14'h155, 3'd3, 16'h0030);
    step();
    chk("f4_load_addr", out_addr, 16'h0030);
    drive(1'b1, 14'h156, 3'd4, 16'h0031);
    step();
    chk("f4_in_ready", in_ready, 0);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f4_out_valid", out_valid, 0);
    chk("f4_out_ctrl", out_ctrl, 0);
    chk("f4_in_ready_after", in_ready, 1);
    chk("f4_stall_cnt", stall_cnt, 7);
    out_ready = 1'b1;
    step();
    chk("f4_skid_empty", out_valid, 0);

    // 5. Flush drops the instruction offered in the same cycle
    flush = 1'b1;
    drive(1'b1, 14'h0F0, 3'd5, 16'h0050);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("f5_out_valid", out_valid, 0);
    chk("f5_out_dst", out_dst, 0);
    step();
    chk("f5_still_empty", out_valid, 0);

    // 6. Reset clears the counters
    reset = 1'b0;
    step();
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_sat_cnt", s_stall_cnt, 0);
    reset = 1'b1;
    step();
    chk("rst2_cnt_idle", stall_cnt, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
